column_feeder: RTL

COLUMN_FEEDER -- requirements
Module: column_feeder

---
 rtl/cnn_pkg.sv | 19 +
 rtl/column_feeder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
// Holds the column feeder state type, default pixel width and an index-width helper.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        FILL,
        SEND_A,
        SEND_B,
        GAP
    } feeder_state_t;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/column_feeder.sv
// Column feeder: buffers one stripe of mat_height rows in raster order, then
// streams it out as 2-column windows, one column per cycle, with a gap cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    in_data carries a pixel
//   in_ready    block accepts a pixel this cycle (only while filling)
//   in_data     pixel, raster order
//   col_valid   first column of a window is on col_data
//   col_data    one lane per stripe row (index = row)
//   stripe_done one-cycle pulse after the last window of a stripe
module column_feeder
    import cnn_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int mat_height = 2,
    parameter int row_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    output logic                  col_valid,
    output logic [data_width-1:0] col_data [mat_height],
    output logic                  stripe_done
);

    localparam int NPIX = mat_height * row_width;
    localparam int NW   = idx_width(NPIX);
    localparam int CW   = idx_width(row_width);
    localparam int RW   = idx_width(mat_height);
    localparam int KW   = idx_width(row_width / 2);

    generate
        if ((row_width % 2) != 0 || row_width < 2) begin : g_bad_row_width
            $error("column_feeder: row_width must be even and at least 2");
        end
    endgenerate

    feeder_state_t state, state_n;

    logic [NW-1:0] count, count_n;
    logic [KW-1:0] k, k_n;

    logic          accept;
    logic          last_pix;
    logic          last_k;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [CW-1:0] rd_col;

    logic                  valid_n;
    logic                  ready_n;
    logic                  done_n;
    logic [data_width-1:0] data_n [mat_height];

    logic [data_width-1:0] mem [mat_height][row_width];

    // in_ready is high exactly while in FILL, so it doubles as the fill gate.
    assign accept   = in_valid && in_ready;
    assign last_pix = (count == NW'(NPIX - 1));
    assign last_k   = (k == KW'(row_width / 2 - 1));
    assign wr_row   = RW'(32'(count) / row_width);
    assign wr_col   = CW'(32'(count) % row_width);

    // Stripe storage; frozen outside FILL because accept is gated.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_row][wr_col] <= in_data;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        k_n     = k;
        done_n  = 1'b0;
        unique case (state)
            FILL: begin
                if (accept) begin
                    if (last_pix) begin
                        state_n = SEND_A;
                        k_n     = '0;
                    end else begin
                        count_n = count + NW'(1);
                    end
                end
            end
            SEND_A: state_n = SEND_B;
            SEND_B: state_n = GAP;
            GAP: begin
                if (last_k) begin
                    state_n = FILL;
                    count_n = '0;
                    done_n  = 1'b1;
                end else begin
                    state_n = SEND_A;
                    k_n     = k + KW'(1);
                end
            end
            default: state_n = FILL;
        endcase
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        valid_n = (state_n == SEND_A);
        ready_n = (state_n == FILL);
        rd_col  = CW'({k_n, 1'b0});
        if (state_n == SEND_B) begin
            rd_col = CW'({k_n, 1'b1});
        end
        for (int r = 0; r < mat_height; r++) begin
            data_n[r] = '0;
            if (state_n == SEND_A || state_n == SEND_B) begin
                data_n[r] = mem[r][rd_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            count       <= '0;
            k           <= '0;
            in_ready    <= 1'b1;
            col_valid   <= 1'b0;
            stripe_done <= 1'b0;
            for (int r = 0; r < mat_height; r++) begin
                col_data[r] <= '0;
            end
        end else begin
            state       <= state_n;
            count       <= count_n;
            k           <= k_n;
            in_ready    <= ready_n;
            col_valid   <= valid_n;
            stripe_done <= done_n;
            col_data    <= data_n;
        end
    end

endmodule
